// File: rtl/fsm_mon_pkg.sv
// Shared definitions for the FSM transition monitor: trigger re-arm modes and
// the saturating increment used by every channel counter.
package fsm_mon_pkg;

   localparam int MODE_STICKY   = 0;
   localparam int MODE_PERIODIC = 1;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] maxVal;
      maxVal = (32'd1 << width) - 32'd1;
      return (value >= maxVal) ? maxVal : value + 32'd1;
   endfunction

endpackage

// File: rtl/fsm_trans_monitor_if.sv
// Bundle of observed state, per-channel configuration and monitor results.
// The master drives stimulus and configuration; the monitor is the slave.
interface fsm_trans_monitor_if #(
   parameter int STATE_W = 4,
   parameter int N_CH    = 2,
   parameter int CNT_W   = 8
);
   logic [STATE_W-1:0]      state_cur;
   logic                    state_vld;
   logic [N_CH*STATE_W-1:0] cfg_from;
   logic [N_CH*STATE_W-1:0] cfg_to;
   logic [N_CH*CNT_W-1:0]   cfg_thresh;
   logic [N_CH-1:0]         cfg_en;
   logic [N_CH-1:0]         clr;
   logic [N_CH-1:0]         hit;
   logic [N_CH-1:0]         trig;
   logic [N_CH*CNT_W-1:0]   cnt;
   logic                    any_trig;

   modport master (
      output state_cur, state_vld, cfg_from, cfg_to, cfg_thresh, cfg_en, clr,
      input  hit, trig, cnt, any_trig
   );

   modport slave (
      input  state_cur, state_vld, cfg_from, cfg_to, cfg_thresh, cfg_en, clr,
      output hit, trig, cnt, any_trig
   );
endinterface

// File: rtl/trans_ctr_ch.sv
// One watch channel: saturating match counter with a threshold trigger that is
// either held until cleared or pulsed with a counter restart.
module trans_ctr_ch
   import fsm_mon_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int MODE  = MODE_STICKY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_match,
   input  logic [CNT_W-1:0] i_thresh,
   input  logic             i_clr,
   output logic             o_hit,
   output logic             o_trig,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;
   logic             r_hit;
   logic             r_trig;
   logic [CNT_W-1:0] w_inc;
   logic             w_trigCond;

   assign w_inc      = CNT_W'(sat_inc(32'(r_cnt), CNT_W));
   assign w_trigCond = i_match && (i_thresh != '0) && (w_inc >= i_thresh);

   // A clear beats a coincident match, so that match leaves no trace at all
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_hit  <= 1'b0;
         r_trig <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_hit  <= 1'b0;
         r_trig <= 1'b0;
      end else begin
         r_hit <= i_match;
         if (MODE == MODE_PERIODIC) begin
            r_trig <= w_trigCond;
            if (i_match)
               r_cnt <= w_trigCond ? '0 : w_inc;
         end else begin
            r_trig <= r_trig | w_trigCond;
            if (i_match)
               r_cnt <= w_inc;
         end
      end
   end

   assign o_hit  = r_hit;
   assign o_trig = r_trig;
   assign o_cnt  = r_cnt;
endmodule

// File: rtl/fsm_trans_monitor.sv
// Multi-channel transition monitor: keeps one cycle of state history and
// hands each channel a match strobe for its programmed (from, to) pair.
module fsm_trans_monitor
   import fsm_mon_pkg::*;
#(
   parameter int STATE_W = 4,
   parameter int N_CH    = 2,
   parameter int CNT_W   = 8,
   parameter int MODE    = MODE_STICKY
) (
   input logic                  clk,
   input logic                  rst,
   fsm_trans_monitor_if.slave   bus
);
   logic [STATE_W-1:0]    r_prevState;
   logic                  r_prevVld;
   logic [N_CH-1:0]       w_match;
   logic [N_CH-1:0]       w_hit;
   logic [N_CH-1:0]       w_trig;
   logic [N_CH*CNT_W-1:0] w_cnt;

   // History always follows the bus, so an invalid cycle breaks the next match
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prevState <= '0;
         r_prevVld   <= 1'b0;
      end else begin
         r_prevState <= bus.state_cur;
         r_prevVld   <= bus.state_vld;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign w_match[i] = bus.state_vld & r_prevVld & bus.cfg_en[i]
                        & (r_prevState   == bus.cfg_from[i*STATE_W +: STATE_W])
                        & (bus.state_cur == bus.cfg_to[i*STATE_W +: STATE_W]);

      trans_ctr_ch #(
         .CNT_W (CNT_W),
         .MODE  (MODE)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_match  (w_match[i]),
         .i_thresh (bus.cfg_thresh[i*CNT_W +: CNT_W]),
         .i_clr    (bus.clr[i]),
         .o_hit    (w_hit[i]),
         .o_trig   (w_trig[i]),
         .o_cnt    (w_cnt[i*CNT_W +: CNT_W])
      );
   end

   assign bus.hit      = w_hit;
   assign bus.trig     = w_trig;
   assign bus.cnt      = w_cnt;
   assign bus.any_trig = |w_trig;
endmodule

// File: tb/tb_fsm_trans_monitor.sv
// Directed bench for fsm_trans_monitor: three instances (sticky, periodic,
// narrow counter) share one state stream and are checked against hand values.
module tb_fsm_trans_monitor;

   logic clk;
   logic rst;
   int   nChecks;
   int   nErrors;

   fsm_trans_monitor_if #(.STATE_W(4), .N_CH(2), .CNT_W(8)) ifA ();
   fsm_trans_monitor_if #(.STATE_W(4), .N_CH(1), .CNT_W(8)) ifB ();
   fsm_trans_monitor_if #(.STATE_W(4), .N_CH(1), .CNT_W(3)) ifC ();

   fsm_trans_monitor #(.STATE_W(4), .N_CH(2), .CNT_W(8), .MODE(0)) dutA (
      .clk (clk), .rst (rst), .bus (ifA)
   );
   fsm_trans_monitor #(.STATE_W(4), .N_CH(1), .CNT_W(8), .MODE(1)) dutB (
      .clk (clk), .rst (rst), .bus (ifB)
   );
   fsm_trans_monitor #(.STATE_W(4), .N_CH(1), .CNT_W(3), .MODE(0)) dutC (
      .clk (clk), .rst (rst), .bus (ifC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] state;
      logic       vld;
      logic       clr;
      int         aCnt;
      int         aHit;
      int         aTrig;
      int         bCnt;
      int         bTrig;
      int         cCnt;
   } vec_t;

   vec_t tbl[20];

   task automatic applyStimulus(input logic [3:0] st, input logic v);
      ifA.state_cur = st; ifA.state_vld = v;
      ifB.state_cur = st; ifB.state_vld = v;
      ifC.state_cur = st; ifC.state_vld = v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      nChecks = 0;
      nErrors = 0;

      // Sticky/periodic/saturating channels all watch 3->7; sticky ch1 watches 6->6
      tbl[0]  = '{4'd3, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{4'd7, 1'b1, 1'b0, 1, 1, 0, 1, 0, 1};
      tbl[2]  = '{4'd0, 1'b1, 1'b0, 1, 0, 0, 1, 0, 1};
      tbl[3]  = '{4'd3, 1'b1, 1'b0, 1, 0, 0, 1, 0, 1};
      tbl[4]  = '{4'd7, 1'b1, 1'b0, 2, 1, 0, 0, 1, 2};
      tbl[5]  = '{4'd0, 1'b1, 1'b0, 2, 0, 0, 0, 0, 2};
      tbl[6]  = '{4'd3, 1'b1, 1'b0, 2, 0, 0, 0, 0, 2};
      tbl[7]  = '{4'd7, 1'b1, 1'b0, 3, 1, 0, 1, 0, 3};
      tbl[8]  = '{4'd0, 1'b1, 1'b0, 3, 0, 0, 1, 0, 3};
      tbl[9]  = '{4'd3, 1'b1, 1'b0, 3, 0, 0, 1, 0, 3};
      tbl[10] = '{4'd7, 1'b1, 1'b0, 4, 1, 0, 0, 1, 4};
      tbl[11] = '{4'd0, 1'b1, 1'b0, 4, 0, 0, 0, 0, 4};
      tbl[12] = '{4'd3, 1'b1, 1'b0, 4, 0, 0, 0, 0, 4};
      tbl[13] = '{4'd7, 1'b1, 1'b0, 5, 1, 1, 1, 0, 5};
      tbl[14] = '{4'd0, 1'b1, 1'b0, 5, 0, 1, 1, 0, 5};
      tbl[15] = '{4'd0, 1'b1, 1'b0, 5, 0, 1, 1, 0, 5};
      tbl[16] = '{4'd3, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
      tbl[17] = '{4'd7, 1'b1, 1'b0, 1, 1, 0, 1, 0, 1};
      tbl[18] = '{4'd3, 1'b1, 1'b0, 1, 0, 0, 1, 0, 1};
      tbl[19] = '{4'd7, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0};

      ifA.cfg_from = {4'd6, 4'd3}; ifA.cfg_to = {4'd6, 4'd7};
      ifA.cfg_thresh = {8'd0, 8'd5}; ifA.cfg_en = 2'b11; ifA.clr = 2'b00;
      ifB.cfg_from = 4'd3; ifB.cfg_to = 4'd7;
      ifB.cfg_thresh = 8'd2; ifB.cfg_en = 1'b1; ifB.clr = 1'b0;
      ifC.cfg_from = 4'd3; ifC.cfg_to = 4'd7;
      ifC.cfg_thresh = 3'd0; ifC.cfg_en = 1'b1; ifC.clr = 1'b0;

      rst = 1'b1;
      applyStimulus(4'd0, 1'b0);
      applyStimulus(4'd0, 1'b0);
      checkOutput("rstCntA",  int'(ifA.cnt), 0);
      checkOutput("rstHitA",  int'(ifA.hit), 0);
      checkOutput("rstTrigA", int'(ifA.trig), 0);
      checkOutput("rstAnyA",  int'(ifA.any_trig), 0);
      checkOutput("rstCntB",  int'(ifB.cnt), 0);
      checkOutput("rstCntC",  int'(ifC.cnt), 0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         ifA.clr[0] = tbl[i].clr;
         ifB.clr[0] = tbl[i].clr;
         ifC.clr[0] = tbl[i].clr;
         applyStimulus(tbl[i].state, tbl[i].vld);
         checkOutput($sformatf("row%0d_cntA", i),  int'(ifA.cnt[7:0]), tbl[i].aCnt);
         checkOutput($sformatf("row%0d_hitA", i),  int'(ifA.hit[0]), tbl[i].aHit);
         checkOutput($sformatf("row%0d_trigA", i), int'(ifA.trig[0]), tbl[i].aTrig);
         checkOutput($sformatf("row%0d_anyA", i),  int'(ifA.any_trig), tbl[i].aTrig);
         checkOutput($sformatf("row%0d_cntB", i),  int'(ifB.cnt), tbl[i].bCnt);
         checkOutput($sformatf("row%0d_trigB", i), int'(ifB.trig[0]), tbl[i].bTrig);
         checkOutput($sformatf("row%0d_cntC", i),  int'(ifC.cnt), tbl[i].cCnt);
      end
      ifA.clr = 2'b00; ifB.clr = 1'b0; ifC.clr = 1'b0;

      // Self-loop dwell on A ch1: first cycle of 6 follows a 7, so it is not counted
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(4'd6, 1'b1);
         checkOutput($sformatf("dwell%0d_cnt", k), int'(ifA.cnt[15:8]), k - 1);
         checkOutput($sformatf("dwell%0d_hit", k), int'(ifA.hit[1]), (k >= 2) ? 1 : 0);
      end
      checkOutput("dwellTrigNever", int'(ifA.trig[1]), 0);

      ifA.clr = 2'b10;
      applyStimulus(4'd0, 1'b1);
      ifA.clr = 2'b00;
      checkOutput("dwellClr", int'(ifA.cnt[15:8]), 0);
      for (int k = 0; k < 5; k++) applyStimulus(4'd6, 1'b1);
      applyStimulus(4'd6, 1'b0);
      checkOutput("gapHit", int'(ifA.hit[1]), 0);
      for (int k = 0; k < 5; k++) applyStimulus(4'd6, 1'b1);
      checkOutput("gapCnt", int'(ifA.cnt[15:8]), 8);

      // Narrow counter saturates at 7 and a zero threshold never triggers
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(4'd3, 1'b1);
         applyStimulus(4'd7, 1'b1);
         checkOutput($sformatf("sat%0d_cntC", k), int'(ifC.cnt), (k > 7) ? 7 : k);
         checkOutput($sformatf("sat%0d_trigC", k), int'(ifC.trig), 0);
      end

      ifA.clr = 2'b01;
      applyStimulus(4'd0, 1'b1);
      ifA.clr = 2'b00;
      checkOutput("preRstClr", int'(ifA.cnt[7:0]), 0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(4'd3, 1'b1);
         applyStimulus(4'd7, 1'b1);
      end
      checkOutput("preRstCnt", int'(ifA.cnt[7:0]), 4);
      checkOutput("preRstHit", int'(ifA.hit[0]), 1);

      rst = 1'b1;
      applyStimulus(4'd3, 1'b1);
      rst = 1'b0;
      checkOutput("midRstCntA0", int'(ifA.cnt[7:0]), 0);
      checkOutput("midRstCntA1", int'(ifA.cnt[15:8]), 0);
      checkOutput("midRstHitA",  int'(ifA.hit), 0);
      checkOutput("midRstAnyA",  int'(ifA.any_trig), 0);
      checkOutput("midRstCntC",  int'(ifC.cnt), 0);

      applyStimulus(4'd7, 1'b1);
      checkOutput("postRstNoMatchCnt", int'(ifA.cnt[7:0]), 0);
      checkOutput("postRstNoMatchHit", int'(ifA.hit[0]), 0);
      applyStimulus(4'd3, 1'b1);
      applyStimulus(4'd7, 1'b1);
      checkOutput("postRstMatchCnt", int'(ifA.cnt[7:0]), 1);
      checkOutput("postRstMatchHit", int'(ifA.hit[0]), 1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/fsm_trans_monitor.md
# fsm_trans_monitor

Parametrised transition-event monitor for the FSM benchmark suite. It watches a state bus and counts occurrences of up to N_CH configurable (from, to) state transitions, with one saturating counter per channel. When a channel's count reaches its programmed threshold, it raises a trigger, either sticky or periodic. It sits beside a benchmark controller and generalises a single hard-coded event counter into a multi-channel, runtime-configured block with a selectable re-arm mode.

## Interface
- STATE_W, 4, width of the observed state encoding
- N_CH, 2, number of independent watch channels
- CNT_W, 8, counter width per channel
- MODE, 0, 0 = sticky trigger held until clr; 1 = periodic trigger, one-cycle pulse and counter restart

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- state_cur  in  STATE_W  observed FSM state
- state_vld  in  1  state_cur is meaningful this cycle
- cfg_from  in  N_CH*STATE_W  per-channel source state; channel i occupies bits [i*STATE_W +: STATE_W]
- cfg_to  in  N_CH*STATE_W  per-channel destination state
- cfg_thresh  in  N_CH*CNT_W  per-channel trigger threshold; 0 disables the trigger
- cfg_en  in  N_CH  channel enable; when low, the counter holds
- clr  in  N_CH  per-channel clear of counter, hit and trigger
- hit  out  N_CH  one-cycle pulse: watched transition seen
- trig  out  N_CH  threshold trigger (sticky or pulse per MODE)
- cnt  out  N_CH*CNT_W  current count per channel
- any_trig  out  1  OR of trig

## Operation
- Registered history: prev_state and prev_vld are updated every cycle from state_cur and state_vld.
- Match for channel i:
  - condition is state_vld & prev_vld & cfg_en[i] & prev_state==cfg_from[i] & state_cur==cfg_to[i];
  - if from==to, every consecutive valid dwell cycle counts as a match.
- Counter: on a match, cnt increments by 1, saturating at 2^CNT_W-1. A saturated counter stays at its maximum.
- Trigger condition: a match whose post-increment count is >= thresh, with thresh != 0.
- MODE 0:
  - trig is set on the trigger condition and stays set until clr or rst;
  - after the trigger, cnt keeps counting up to saturation.
- MODE 1:
  - trig pulses for one cycle on the trigger condition;
  - the same update writes cnt = 0 instead of the incremented value.
- Priority per channel: rst > clr > match. If clr and a match occur in the same cycle, clr wins, the count is 0 and no hit is produced.
- cfg_* changes take effect on the next comparison and do not reset the counter. If thresh is lowered below the current count, the trigger fires on the next match.
- Deasserting state_vld breaks the history. The first valid cycle after a gap is never a match.
- Reset values: hit=0, trig=0, cnt=0, any_trig=0, prev_vld=0, prev_state=0.

## Timing
- Transition observed when state_cur is sampled at edge t while prev_state holds the value from t-1. hit, cnt and trig update at edge t, visible in cycle t+1. Latency is 1 cycle from the destination state being presented.
- any_trig is combinational from the trig registers, so it adds no extra latency.
- Back-to-back matches (self-loop dwell) give one increment per cycle, with no dead cycles.
- Reset mid-count clears everything on the next edge. Monitoring resumes with prev_vld=0, so the first post-reset cycle cannot match.

## Structure
- Shared package fsm_mon_pkg holds:
  - MODE_STICKY=0 and MODE_PERIODIC=1;
  - helper function sat_inc(value, width).
- Sub-module trans_ctr_ch, one instance per channel: match in, cfg_thresh slice, clr bit; outputs hit, trig, cnt slice.
- The top level holds the prev_state/prev_vld history, the channel generate loop and the any_trig reduction.

## Test plan
- STATE_W=4, MODE=0, ch0 from=3 to=7 thresh=5. Drive 3→7 five times with other states in between → cnt0 goes 1..5, hit0 pulses each time, trig0 rises with cnt0=5 and stays high until clr0.
- MODE=1, thresh=2, four 3→7 transitions → cnt0 sequence 1,0,1,0 and trig0 pulses after the 2nd and 4th transitions.
- Self-loop: from=to=6, state_cur=6 for 10 valid cycles → cnt0=9, with the first cycle not counted. Deassert state_vld for one cycle mid-dwell → one fewer increment.
- CNT_W=3, thresh=0, 12 matches → cnt0 saturates at 7 and trig0 never asserts.
- Simultaneous clr0 and match → cnt0=0, hit0=0, trig0=0. rst asserted mid-count (cnt0=4) → all outputs 0 the next cycle, and a 3→7 immediately after reset release is not counted unless state 3 was presented after the release.
